instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_pkg.sv | 14 +
 rtl/instr_mem_loader_byte_packer.sv | 39 +++
 rtl/instr_mem_loader.sv | 131 +++++++++++++
 tb/tb_instr_mem_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared loader state encoding and constants
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } load_state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int          BYTE_CNT_W        = 2;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// rtl/instr_mem_loader_byte_packer.sv - 4-byte little-endian word assembler
module instr_mem_loader_byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [BYTE_CNT_W-1:0] cnt_q;
  logic [23:0]           low_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      low_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
      low_q <= '0;
    end else if (byte_valid) begin
      cnt_q <= cnt_q + BYTE_CNT_W'(1);
      case (cnt_q)
        2'd0:    low_q[7:0]   <= byte_data;
        2'd1:    low_q[15:8]  <= byte_data;
        2'd2:    low_q[23:16] <= byte_data;
        default: ;
      endcase
    end
  end

  // The fourth byte bypasses storage so the word is available on its own edge.
  assign word_ready = byte_valid && !clear && (cnt_q == '1);
  assign word       = {byte_data, low_q};

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - UART byte stream to instruction RAM program loader
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int                   RAM_WIDTH = 32,
  parameter int                   ADDR_W    = 11,
  parameter logic [RAM_WIDTH-1:0] HALT_WORD = RAM_WIDTH'(HALT_WORD_DEFAULT)
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  input  logic                 start_load,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic [ADDR_W-1:0]    pc_addr,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_we,
  output logic [RAM_WIDTH-1:0] ram_wdata,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 err_full,
  output logic [ADDR_W-2:0]    word_count
);

  localparam int WPTR_W = ADDR_W - 2;
  localparam int CNT_W  = ADDR_W - 1;

  load_state_t            state_q, state_d;
  logic [WPTR_W-1:0]      wptr_q;
  logic [CNT_W-1:0]       word_count_q;
  logic [RAM_WIDTH-1:0]   wdata_q;
  logic                   load_done_q;
  logic                   err_full_q;

  logic                   start_ok;
  logic                   is_halt;
  logic                   is_last;
  logic                   pk_valid;
  logic                   pk_ready;
  logic [31:0]            pk_word;

  assign is_halt = (wdata_q == HALT_WORD);
  assign is_last = (wptr_q == '1);

  // A byte arriving during WRITE starts the next word unless the load is ending.
  assign pk_valid = rx_valid &&
                    ((state_q == ST_LOAD) ||
                     ((state_q == ST_WRITE) && !(is_halt || is_last)));

  instr_mem_loader_byte_packer u_byte_packer (
    .clk        (clka),
    .rst_n      (rsta_n),
    .clear      (start_ok),
    .byte_valid (pk_valid),
    .byte_data  (rx_data),
    .word_ready (pk_ready),
    .word       (pk_word)
  );

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    ram_we   = 1'b0;
    cpu_hold = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_load) begin
          start_ok = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cpu_hold = 1'b1;
        if (pk_ready) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        cpu_hold = 1'b1;
        ram_we   = 1'b1;
        state_d  = (is_halt || is_last) ? ST_DONE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      wptr_q       <= '0;
      word_count_q <= '0;
      wdata_q      <= '0;
      load_done_q  <= 1'b0;
      err_full_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_load) begin
            wptr_q       <= '0;
            word_count_q <= '0;
            load_done_q  <= 1'b0;
            err_full_q   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (pk_ready) wdata_q <= RAM_WIDTH'(pk_word);
        end
        ST_WRITE: begin
          word_count_q <= word_count_q + CNT_W'(1);
          if (is_halt) begin
            load_done_q <= 1'b1;
          end else if (is_last) begin
            load_done_q <= 1'b1;
            err_full_q  <= 1'b1;
          end else begin
            wptr_q <= wptr_q + WPTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_addr   = cpu_hold ? {wptr_q, 2'b00} : pc_addr;
  assign ram_wdata  = wdata_q;
  assign load_done  = load_done_q;
  assign err_full   = err_full_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - scoreboard bench for instr_mem_loader
module tb_instr_mem_loader;

  localparam int          BIG_CAP   = 512;
  localparam int          SMALL_CAP = 4;
  localparam logic [31:0] HALT      = 32'hFFFF_FFFF;

  logic        clka = 1'b0;
  logic        rsta_n;
  logic        start_load;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [10:0] pc_addr;

  logic [10:0] b_ram_addr;
  logic        b_ram_we;
  logic [31:0] b_ram_wdata;
  logic        b_cpu_hold, b_load_done, b_err_full;
  logic [9:0]  b_word_count;

  logic [3:0]  s_ram_addr;
  logic        s_ram_we;
  logic [31:0] s_ram_wdata;
  logic        s_cpu_hold, s_load_done, s_err_full;
  logic [2:0]  s_word_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_b[$];
  logic [63:0] exp_s[$];
  int          exp_b_cnt, exp_s_cnt;
  bit          exp_b_err, exp_s_err;

  always #5 clka = ~clka;

  instr_mem_loader #(.ADDR_W(11)) u_big (
    .clka       (clka),
    .rsta_n     (rsta_n),
    .start_load (start_load),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .pc_addr    (pc_addr),
    .ram_addr   (b_ram_addr),
    .ram_we     (b_ram_we),
    .ram_wdata  (b_ram_wdata),
    .cpu_hold   (b_cpu_hold),
    .load_done  (b_load_done),
    .err_full   (b_err_full),
    .word_count (b_word_count)
  );

  instr_mem_loader #(.ADDR_W(4)) u_small (
    .clka       (clka),
    .rsta_n     (rsta_n),
    .start_load (start_load),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .pc_addr    (pc_addr[3:0]),
    .ram_addr   (s_ram_addr),
    .ram_we     (s_ram_we),
    .ram_wdata  (s_ram_wdata),
    .cpu_hold   (s_cpu_hold),
    .load_done  (s_load_done),
    .err_full   (s_err_full),
    .word_count (s_word_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Write monitors: the RAM captures on the falling edge, so do we.
  always @(negedge clka) begin
    if (b_ram_we === 1'b1) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL big_unexpected_write actual=%h@%h expected=none", b_ram_wdata, b_ram_addr);
      end else begin
        logic [63:0] e;
        e = exp_b.pop_front();
        chk("big_write_addr", 32'(b_ram_addr), e[63:32]);
        chk("big_write_data", b_ram_wdata, e[31:0]);
      end
    end
  end

  always @(negedge clka) begin
    if (s_ram_we === 1'b1) begin
      if (exp_s.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL small_unexpected_write actual=%h@%h expected=none", s_ram_wdata, s_ram_addr);
      end else begin
        logic [63:0] e;
        e = exp_s.pop_front();
        chk("small_write_addr", 32'(s_ram_addr), e[63:32]);
        chk("small_write_data", s_ram_wdata, e[31:0]);
      end
    end
  end

  // Reference: words are written in order from address 0 until the halt
  // word (inclusive) or until capacity runs out, which flags err_full.
  task automatic model_one(input logic [31:0] words[$], input int cap, input bit big);
    int n;
    bit err;
    bit stop;
    n = 0;
    err = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < words.size() && !stop; i++) begin
      if (big) exp_b.push_back({32'(n * 4), words[i]});
      else     exp_s.push_back({32'(n * 4), words[i]});
      n++;
      if (words[i] == HALT) stop = 1'b1;
      else if (n == cap) begin
        stop = 1'b1;
        err  = 1'b1;
      end
    end
    if (big) begin exp_b_cnt = n; exp_b_err = err; end
    else     begin exp_s_cnt = n; exp_s_err = err; end
  endtask

  task automatic model_load(input logic [31:0] words[$]);
    model_one(words, BIG_CAP, 1'b1);
    model_one(words, SMALL_CAP, 1'b0);
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
  endtask

  task automatic send_words(input logic [31:0] words[$], input int gmax);
    logic [31:0] w;
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8]);
        repeat ($urandom_range(gmax, 0)) tick();
      end
    end
  endtask

  task automatic check_end();
    repeat (6) tick();
    chk("big_load_done",    32'(b_load_done),  32'd1);
    chk("big_err_full",     32'(b_err_full),   32'(exp_b_err));
    chk("big_word_count",   32'(b_word_count), 32'(exp_b_cnt));
    chk("big_cpu_hold",     32'(b_cpu_hold),   32'd0);
    chk("big_pending",      32'(exp_b.size()), 32'd0);
    chk("small_load_done",  32'(s_load_done),  32'd1);
    chk("small_err_full",   32'(s_err_full),   32'(exp_s_err));
    chk("small_word_count", 32'(s_word_count), 32'(exp_s_cnt));
    chk("small_cpu_hold",   32'(s_cpu_hold),   32'd0);
    chk("small_pending",    32'(exp_s.size()), 32'd0);
  endtask

  task automatic run_load(input logic [31:0] words[$], input int gmax);
    model_load(words);
    pulse_start();
    send_words(words, gmax);
    check_end();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_big_hold"},   32'(b_cpu_hold),   32'd0);
    chk({tag, "_big_we"},     32'(b_ram_we),     32'd0);
    chk({tag, "_big_done"},   32'(b_load_done),  32'd0);
    chk({tag, "_big_err"},    32'(b_err_full),   32'd0);
    chk({tag, "_big_count"},  32'(b_word_count), 32'd0);
    chk({tag, "_big_wdata"},  b_ram_wdata,       32'd0);
    chk({tag, "_big_addr"},   32'(b_ram_addr),   32'(pc_addr));
    chk({tag, "_small_hold"}, 32'(s_cpu_hold),   32'd0);
    chk({tag, "_small_we"},   32'(s_ram_we),     32'd0);
    chk({tag, "_small_count"},32'(s_word_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] words[$];
    logic [31:0] w0;

    rsta_n     = 1'b0;
    start_load = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    pc_addr    = 11'h000;
    #1;
    check_reset_outputs("reset");
    repeat (2) tick();
    pc_addr = 11'h010;
    rsta_n  = 1'b1;
    tick();
    chk("idle_big_addr",   32'(b_ram_addr),  32'h010);
    chk("idle_small_addr", 32'(s_ram_addr),  32'h0);
    chk("idle_big_hold",   32'(b_cpu_hold),  32'd0);
    chk("idle_big_we",     32'(b_ram_we),    32'd0);
    chk("idle_big_done",   32'(b_load_done), 32'd0);

    // Basic three-word program ending in the marker.
    words = '{32'h1234_5678, 32'hDEAD_BEEF, HALT};
    run_load(words, 2);

    // Overflow on the 4-word instance; the large instance keeps going to the marker.
    words = '{$urandom() & 32'h7FFF_FFFF, 32'h0102_0304, 32'hA5A5_5A5A, 32'h0BAD_F00D, HALT};
    run_load(words, 1);

    // Back-to-back bytes put the fifth byte in the WRITE cycle of word 0.
    words = '{32'hCAFE_0001, 32'h7766_55AA, HALT};
    run_load(words, 0);

    // Reset with two bytes of word 1 received: word 0 stays written, rest discarded.
    w0 = 32'h0BAD_CAFE;
    words = '{w0};
    model_load(words);
    pulse_start();
    send_words(words, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (3) tick();
    #2;
    rsta_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    chk("abort_big_pending", 32'(exp_b.size()), 32'd0);
    @(posedge clka);
    #1;
    rsta_n = 1'b1;
    tick();
    words = '{32'h600D_0000, HALT};
    run_load(words, 2);

    // start_load in the middle of a load is ignored.
    words = '{32'h4433_2211, HALT};
    model_load(words);
    pulse_start();
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_start();
    send_byte(8'h33);
    send_byte(8'h44);
    send_words('{HALT}, 1);
    check_end();

    // start_load in DONE clears the flags and restarts at address 0.
    pulse_start();
    chk("restart_big_done",   32'(b_load_done),  32'd0);
    chk("restart_big_count",  32'(b_word_count), 32'd0);
    chk("restart_big_hold",   32'(b_cpu_hold),   32'd1);
    chk("restart_small_done", 32'(s_load_done),  32'd0);
    words = '{32'h0000_0013, HALT};
    model_load(words);
    send_words(words, 1);
    check_end();

    for (int l = 0; l < 15; l++) begin
      int nw;
      nw = $urandom_range(7, 1);
      words = {};
      for (int i = 0; i < nw; i++) words.push_back($urandom());
      words.push_back(HALT);
      run_load(words, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
